decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//   Registered, parametrised RV32I decode stage between fetch and execute.
//   Accepts {instr, pc} over a valid/ready handshake. Splits out the register
//   and function fields, and builds the fully sign-extended byte-offset
//   immediate for I/S/B/U/J formats. Flags illegal opcodes.
//   A 2-entry output buffer (main register + skid) absorbs execute back-pressure
//   without combinational ready paths. A flush input kills in-flight entries
//   on branch redirect.
// PARAMETERS
//   WIDTH     32  datapath/XLEN width of instr, pc, imm_ext (>=32)
//   SKID_EN   1   1: 2-entry skid buffer; 0: single register, in_ready = !out_valid | out_ready
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   flush      in   1      synchronous kill of all buffered entries
//   in_valid   in   1      fetch presents instr/pc
//   in_ready   out  1      stage can accept this cycle
//   in_instr   in   WIDTH  raw instruction (bits [31:0] used)
//   in_pc      in   WIDTH  instruction address
//   out_valid  out  1      decoded entry presented to execute
//   out_ready  in   1      execute consumes entry
//   out_pc     out  WIDTH  pc of presented entry
//   opcode     out  7      instr[6:0]
//   rd         out  5      instr[11:7]
//   funct3     out  3      instr[14:12]
//   rs1        out  5      instr[19:15]
//   rs2        out  5      instr[24:20]
//   funct7     out  7      instr[31:25]
//   imm_ext    out  WIDTH  sign-extended immediate, format per opcode
//   illegal    out  1      opcode not in supported set
// BEHAVIOUR
//   Reset: out_valid=0, skid empty, in_ready=1; all data outputs 0.
//   Transfer rules: input fires on in_valid&in_ready; output fires on out_valid&out_ready.
//   Latency: accepted entry appears on outputs the next cycle (1 cycle).
//   Throughput: 1 entry/cycle while out_ready=1.
//   Buffer states (SKID_EN=1): EMPTY, ONE (main valid), TWO (main+skid valid).
//     EMPTY -in fire-> ONE.
//     ONE: in fire & out fire -> ONE (new data); out fire only -> EMPTY;
//       in fire only -> TWO (new entry held in skid).
//     TWO: out fire -> ONE (skid moves to main).
//     in_ready = (state!=TWO), driven from a register only.
//   Order is strictly FIFO. No entry is dropped or duplicated.
//   flush: next state EMPTY, out_valid=0. An in fire in the same cycle is
//     discarded. flush has priority over all other events.
//   Decode (combinational on input, stored with entry):
//     I/LOAD/JALR (0010011/0000011/1100111): sext(instr[31:20])
//     S (0100011): sext({instr[31:25],instr[11:7]})
//     B (1100011): sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
//     J (1101111): sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
//     U LUI/AUIPC (0110111/0010111): sext({instr[31:12],12'b0})
//     R (0110011): 0
//     B and J immediates are byte offsets with LSB=0.
//     Sign extension is from the top immediate bit to WIDTH.
//   illegal=1 for any other opcode, or instr[1:0]!=2'b11. imm_ext=0 in that case.
//     The entry still flows through the stage; execute decides on traps.
//   Output fields are held stable while out_valid&!out_ready.
// TESTING
//   addi x1,x0,-1 0xFFF00093 -> next cycle out_valid=1, rd=1, rs1=0, imm_ext=0xFFFFFFFF, illegal=0
//   beq x0,x0,-4 0xFE000EE3 -> imm_ext=0xFFFFFFFC; lui x5,0x12345 0x123452B7 -> rd=5, imm_ext=0x12345000
//   instr 0x00000000 -> illegal=1, imm_ext=0; the following valid instr decodes normally
//   out_ready=0; push A,B -> in_ready=0 after B; C stalls; release -> A,B,C out in order, no loss
//   Back-pressure held with buffer TWO; assert flush -> next cycle out_valid=0, in_ready=1; pre-flush entries never appear
//   rst asserted mid-stream (async, off clock edge) -> out_valid=0, in_ready=1 immediately; first post-reset instr decodes correctly

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: registered field split and immediate build, with a
// two-entry output buffer (main + skid) so in_ready never depends on out_ready.
module decode_stage #(
  parameter int WIDTH   = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_instr,
  input  logic [WIDTH-1:0] in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [6:0]       opcode,
  output logic [4:0]       rd,
  output logic [2:0]       funct3,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [6:0]       funct7,
  output logic [WIDTH-1:0] imm_ext,
  output logic             illegal
);

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [31:0]      instr;
    logic [WIDTH-1:0] imm;
    logic             illegal;
  } entry_t;

  state_t            state, state_next;
  entry_t            main_q, skid_q, new_entry;
  logic              in_fire, out_fire;
  logic [31:0]       instr;
  logic signed [31:0] imm32;
  logic              dec_illegal;

  assign instr    = in_instr[31:0];
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Immediate is assembled at 32 bits, then sign-extended to WIDTH once.
  always_comb begin
    imm32       = '0;
    dec_illegal = 1'b0;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:                 imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BR:    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_JAL:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      OP_LUI, OP_AUIPC:         imm32 = {instr[31:12], 12'b0};
      OP_REG:                   imm32 = '0;
      default:                  dec_illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
      imm32       = '0;
    end
  end

  always_comb begin
    new_entry.pc      = in_pc;
    new_entry.instr   = instr;
    new_entry.imm     = WIDTH'(imm32);
    new_entry.illegal = dec_illegal;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // With SKID_EN=0, in_ready in ONE implies out_ready, so TWO is unreachable.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (in_fire) state_next = ONE;
      ONE: begin
        if (in_fire && !out_fire)      state_next = TWO;
        else if (!in_fire && out_fire) state_next = EMPTY;
      end
      TWO:     if (out_fire) state_next = ONE;
      default: state_next = EMPTY;
    endcase
    if (flush) state_next = EMPTY;
  end

  always_comb begin
    out_valid = (state != EMPTY);
    if (SKID_EN) in_ready = (state != TWO);
    else         in_ready = (state == EMPTY) || out_ready;
  end

  // NOTE: the buffer registers are reset because they drive the data outputs
  // directly and those must read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      case (state)
        EMPTY: if (in_fire) main_q <= new_entry;
        ONE: begin
          if (in_fire && out_fire) main_q <= new_entry;
          else if (in_fire)        skid_q <= new_entry;
        end
        TWO:     if (out_fire) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign out_pc  = main_q.pc;
  assign opcode  = main_q.instr[6:0];
  assign rd      = main_q.instr[11:7];
  assign funct3  = main_q.instr[14:12];
  assign rs1     = main_q.instr[19:15];
  assign rs2     = main_q.instr[24:20];
  assign funct7  = main_q.instr[31:25];
  assign imm_ext = main_q.imm;
  assign illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, back-pressure, flush and
// asynchronous reset, all with hand-computed expectations.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm_ext;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  decode_stage #(.WIDTH(32), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm_ext(imm_ext), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{32'hFFF00093, 7'h13, 5'd1,  3'd0, 5'd0,  5'd31, 7'h7F, 32'hFFFFFFFF, 1'b0}; // addi x1,x0,-1
    vecs[1] = '{32'hFE000EE3, 7'h63, 5'd29, 3'd0, 5'd0,  5'd0,  7'h7F, 32'hFFFFFFFC, 1'b0}; // beq -4
    vecs[2] = '{32'h123452B7, 7'h37, 5'd5,  3'd5, 5'd8,  5'd3,  7'h09, 32'h12345000, 1'b0}; // lui
    vecs[3] = '{32'h00000000, 7'h00, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'h00000000, 1'b1}; // illegal
    vecs[4] = '{32'hFE552C23, 7'h23, 5'd24, 3'd2, 5'd10, 5'd5,  7'h7F, 32'hFFFFFFF8, 1'b0}; // sw -8
    vecs[5] = '{32'h001000EF, 7'h6F, 5'd1,  3'd0, 5'd0,  5'd1,  7'h00, 32'h00000800, 1'b0}; // jal +2048
    vecs[6] = '{32'h402081B3, 7'h33, 5'd3,  3'd0, 5'd1,  5'd2,  7'h20, 32'h00000000, 1'b0}; // sub
    vecs[7] = '{32'hFFF00090, 7'h10, 5'd1,  3'd0, 5'd0,  5'd31, 7'h7F, 32'h00000000, 1'b1}; // bad [1:0]
    vecs[8] = '{32'hFFFFF117, 7'h17, 5'd2,  3'd7, 5'd31, 5'd31, 7'h7F, 32'hFFFFF000, 1'b0}; // auipc
    vecs[9] = '{32'h0041A203, 7'h03, 5'd4,  3'd2, 5'd3,  5'd4,  7'h00, 32'h00000004, 1'b0}; // lw 4
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic check_vec(input int i, input logic [31:0] pc);
    check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
    check($sformatf("v%0d_pc", i), out_pc, pc);
    check($sformatf("v%0d_opcode", i), 32'(opcode), 32'(vecs[i].op));
    check($sformatf("v%0d_rd", i), 32'(rd), 32'(vecs[i].rd));
    check($sformatf("v%0d_funct3", i), 32'(funct3), 32'(vecs[i].f3));
    check($sformatf("v%0d_rs1", i), 32'(rs1), 32'(vecs[i].rs1));
    check($sformatf("v%0d_rs2", i), 32'(rs2), 32'(vecs[i].rs2));
    check($sformatf("v%0d_funct7", i), 32'(funct7), 32'(vecs[i].f7));
    check($sformatf("v%0d_imm", i), imm_ext, vecs[i].imm);
    check($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_imm", imm_ext, 32'd0);
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming decode, one entry per cycle, 1-cycle latency.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(vecs[i].instr, 32'h100 + 32'(4 * i));
      tick();
      check_vec(i, 32'h100 + 32'(4 * i));
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("drain_empty", 32'(out_valid), 32'd0);

    // Back-pressure: fill both entries, stall a third, release in order.
    out_ready = 1'b0;
    push(32'h00000393, 32'h200);  // addi x7,x0,0
    tick();
    check("bp_a_valid", 32'(out_valid), 32'd1);
    check("bp_a_pc", out_pc, 32'h200);
    check("bp_one_ready", 32'(in_ready), 32'd1);
    push(32'h00100413, 32'h204);  // addi x8,x0,1
    tick();
    check("bp_two_ready", 32'(in_ready), 32'd0);
    check("bp_two_pc", out_pc, 32'h200);
    push(32'h00200493, 32'h208);  // addi x9,x0,2
    tick();
    check("bp_stall_ready", 32'(in_ready), 32'd0);
    check("bp_stall_pc", out_pc, 32'h200);
    check("bp_stall_rd", 32'(rd), 32'd7);
    out_ready = 1'b1;
    tick();
    check("bp_b_pc", out_pc, 32'h204);
    check("bp_b_rd", 32'(rd), 32'd8);
    check("bp_b_imm", imm_ext, 32'd1);
    check("bp_b_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp_c_pc", out_pc, 32'h208);
    check("bp_c_rd", 32'(rd), 32'd9);
    check("bp_c_imm", imm_ext, 32'd2);
    in_valid = 1'b0;
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Flush with the buffer full, then flush racing an accepted input.
    out_ready = 1'b0;
    push(32'hFFF00093, 32'h300);
    tick();
    push(32'h123452B7, 32'h304);
    tick();
    check("fl_two_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    push(32'hFE000EE3, 32'h30C);
    tick();
    check("fl_race_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;
    out_ready = 1'b1;
    push(32'h0041A203, 32'h310);
    tick();
    check("fl_after_pc", out_pc, 32'h310);
    check("fl_after_imm", imm_ext, 32'h4);
    in_valid = 1'b0;
    tick();
    check("fl_after_empty", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a stalled stream.
    out_ready = 1'b0;
    push(32'h00000393, 32'h500);
    tick();
    push(32'h00100413, 32'h504);
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_pc", out_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    push(32'hFFF00093, 32'h400);
    tick();
    check_vec(0, 32'h400);
    in_valid = 1'b0;
    tick();
    check("arst_drained", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
